// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding
// and the forwarding mux select codes.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Priority matcher for one ID-stage operand: EX > MEM > WB > register file.
module pipeline_hazard_controller_forward_select
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_en,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_en,
  output logic [1:0] sel
);

  // r0 reads as zero, so it is never forwarded; unused operands select RF.
  always_comb begin
    sel = FWD_RF;
    if (use_src && (src != 5'd0)) begin
      if (ex_rf_en && (ex_rd == src))        sel = FWD_EX;
      else if (mem_rf_en && (mem_rd == src)) sel = FWD_MEM;
      else if (wb_rf_en && (wb_rd == src))   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline register sequencing: post-reset flush, load-use bubbles,
// delay-slot annulment and ID-stage forwarding selects.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FLUSH    | all pipeline registers held cleared for FLUSH_CYCLES cycles
// RUN      | normal flow; load-use hazard freezes front end for a cycle
// STALL    | single bubble cycle; load now in MEM, front end released
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_use_rd,
  input  logic             id_annul_req,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_en,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_en,
  output logic             pc_le,
  output logic             npc_le,
  output logic             if_id_le,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             ex_mem_clr,
  output logic             mem_wb_clr,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [1:0]       fwd_sel3,
  output logic [CNT_W-1:0] stall_count,
  output logic             busy
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [FCW-1:0]   flush_cnt_q;
  logic [CNT_W-1:0] stall_count_q;
  logic             annul_pending_q;
  logic             annul_clr_q;
  logic             hazard;
  logic [1:0]       raw_sel1, raw_sel2, raw_sel3;

  assign hazard = ex_load && ex_rf_en && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)) ||
                   (id_use_rd  && (id_rd  == ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_FLUSH;
      flush_cnt_q     <= FCW'(FLUSH_CYCLES - 1);
      stall_count_q   <= '0;
      annul_pending_q <= 1'b0;
      annul_clr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - FCW'(1);
          annul_pending_q <= 1'b0;
          annul_clr_q     <= 1'b0;
        end
        ST_RUN: begin
          if (hazard) begin
            if (stall_count_q != '1) stall_count_q <= stall_count_q + CNT_W'(1);
            annul_pending_q <= annul_pending_q | id_annul_req;
            annul_clr_q     <= 1'b0;
          end else begin
            annul_clr_q <= id_annul_req;
          end
        end
        ST_STALL: begin
          // The branch is still in ID here, so a repeated request merges.
          annul_clr_q     <= annul_pending_q | id_annul_req;
          annul_pending_q <= 1'b0;
        end
        default: begin
          annul_pending_q <= 1'b0;
          annul_clr_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FLUSH: if (flush_cnt_q == '0) state_d = ST_RUN;
      ST_RUN:   if (hazard) state_d = ST_STALL;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    pc_le      = 1'b1;
    npc_le     = 1'b1;
    if_id_le   = 1'b1;
    if_id_clr  = annul_clr_q;
    id_ex_clr  = 1'b0;
    ex_mem_clr = 1'b0;
    mem_wb_clr = 1'b0;
    busy       = 1'b0;
    fwd_sel1   = raw_sel1;
    fwd_sel2   = raw_sel2;
    fwd_sel3   = raw_sel3;
    unique case (state_q)
      ST_RUN: begin
        if (hazard) begin
          pc_le     = 1'b0;
          npc_le    = 1'b0;
          if_id_le  = 1'b0;
          id_ex_clr = 1'b1;
        end
      end
      ST_STALL: ;
      default: begin
        pc_le      = 1'b0;
        npc_le     = 1'b0;
        if_id_le   = 1'b0;
        if_id_clr  = 1'b1;
        id_ex_clr  = 1'b1;
        ex_mem_clr = 1'b1;
        mem_wb_clr = 1'b1;
        busy       = 1'b1;
        fwd_sel1   = FWD_RF;
        fwd_sel2   = FWD_RF;
        fwd_sel3   = FWD_RF;
      end
    endcase
  end

  assign stall_count = stall_count_q;

  pipeline_hazard_controller_forward_select u_fwd1 (
    .src(id_rs1), .use_src(id_use_rs1),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .sel(raw_sel1)
  );

  pipeline_hazard_controller_forward_select u_fwd2 (
    .src(id_rs2), .use_src(id_use_rs2),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .sel(raw_sel2)
  );

  pipeline_hazard_controller_forward_select u_fwd3 (
    .src(id_rd), .use_src(id_use_rd),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .sel(raw_sel3)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: cycle model checked every cycle
// plus directed scenarios with literal expectations.
module tb_pipeline_hazard_controller;

  localparam int FC    = 4;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, id_use_rd, id_annul_req;
  logic          ex_rf_en, ex_load, mem_rf_en, wb_rf_en;
  logic          pc_le, npc_le, if_id_le, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, busy;
  logic [1:0]    fwd_sel1, fwd_sel2, fwd_sel3;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_controller #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_rd(id_use_rd),
    .id_annul_req(id_annul_req),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le), .if_id_clr(if_id_clr),
    .id_ex_clr(id_ex_clr), .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .fwd_sel3(fwd_sel3),
    .stall_count(stall_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining flush cycles, bubble flag, counts.
  bit m_valid = 0;
  int m_flush_left;
  bit m_stall;
  int m_count;
  bit m_clr_due;
  bit m_pend;

  function automatic int exp_fwd(input logic [4:0] s, input logic u);
    if (!u || s == 0) return 0;
    if (ex_rf_en && ex_rd == s) return 1;
    if (mem_rf_en && mem_rd == s) return 2;
    if (wb_rf_en && wb_rd == s) return 3;
    return 0;
  endfunction

  function automatic bit load_use();
    if (!(ex_load && ex_rf_en) || ex_rd == 0) return 0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd) ||
           (id_use_rd && id_rd == ex_rd);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_flush_left = FC; m_stall = 0; m_count = 0; m_clr_due = 0; m_pend = 0;
    end else if (m_valid) begin
      if (m_flush_left > 0) begin
        m_flush_left--; m_clr_due = 0; m_pend = 0;
      end else if (m_stall) begin
        m_stall = 0; m_clr_due = m_pend | id_annul_req; m_pend = 0;
      end else if (load_use()) begin
        m_stall = 1; m_clr_due = 0; m_pend = m_pend | id_annul_req;
        if (m_count < CMAX) m_count++;
      end else begin
        m_clr_due = id_annul_req;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit fl, hz;
      fl = (m_flush_left > 0);
      hz = !fl && !m_stall && load_use();
      check("pc_le",      pc_le,      !(fl || hz));
      check("npc_le",     npc_le,     !(fl || hz));
      check("if_id_le",   if_id_le,   !(fl || hz));
      check("if_id_clr",  if_id_clr,  fl ? 1 : m_clr_due);
      check("id_ex_clr",  id_ex_clr,  fl || hz);
      check("ex_mem_clr", ex_mem_clr, fl);
      check("mem_wb_clr", mem_wb_clr, fl);
      check("busy",       busy,       fl);
      check("fwd_sel1",   fwd_sel1,   fl ? 0 : exp_fwd(id_rs1, id_use_rs1));
      check("fwd_sel2",   fwd_sel2,   fl ? 0 : exp_fwd(id_rs2, id_use_rs2));
      check("fwd_sel3",   fwd_sel3,   fl ? 0 : exp_fwd(id_rd, id_use_rd));
      check("stall_count", stall_count, m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_use_rd = 0;
    id_annul_req = 0; ex_rd = 0; ex_rf_en = 0; ex_load = 0;
    mem_rd = 0; mem_rf_en = 0; wb_rd = 0; wb_rf_en = 0;
  endtask

  task automatic load_hazard(input logic [4:0] r);
    ex_load = 1; ex_rf_en = 1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1;
  endtask

  task automatic wait_flush_done(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(name, n, FC);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    wait_flush_done("flush_len");
    @(negedge clk);
    check("run_pc_le", pc_le, 1);
    check("run_busy", busy, 0);
    step();

    // load-use on rs1 = r5
    load_hazard(5);
    @(negedge clk);
    check("hz_pc_le", pc_le, 0);
    check("hz_id_ex_clr", id_ex_clr, 1);
    step();
    idle(); id_rs1 = 5; id_use_rs1 = 1; mem_rd = 5; mem_rf_en = 1;
    @(negedge clk);
    check("stall_cnt1", stall_count, 1);
    check("stall_fwd1", fwd_sel1, 2);
    step(); idle(); step();

    // forwarding priority on rs2 = r7
    ex_rd = 7; mem_rd = 7; wb_rd = 7; ex_rf_en = 1; mem_rf_en = 1; wb_rf_en = 1;
    id_rs2 = 7; id_use_rs2 = 1;
    @(negedge clk); check("fwd_ex", fwd_sel2, 1); step();
    ex_rf_en = 0;
    @(negedge clk); check("fwd_mem", fwd_sel2, 2); step();
    mem_rf_en = 0;
    @(negedge clk); check("fwd_wb", fwd_sel2, 3); step();
    id_rs2 = 0;
    @(negedge clk); check("fwd_r0", fwd_sel2, 0); step();
    id_rs2 = 7; id_use_rs2 = 0;
    @(negedge clk); check("fwd_unused", fwd_sel2, 0); step();
    idle(); id_rd = 9; id_use_rd = 1; mem_rd = 9; mem_rf_en = 1;
    @(negedge clk); check("fwd3_mem", fwd_sel3, 2); step();
    idle(); step();

    // plain annul in RUN
    id_annul_req = 1; step(); id_annul_req = 0;
    @(negedge clk); check("annul_run", if_id_clr, 1); step();
    @(negedge clk); check("annul_run_once", if_id_clr, 0); step();

    // annul coincident with hazard is deferred past the stall
    load_hazard(3); id_annul_req = 1; step();
    idle();
    @(negedge clk); check("annul_in_stall", if_id_clr, 0); step();
    @(negedge clk); check("annul_after_stall", if_id_clr, 1); step();
    @(negedge clk); check("annul_after_once", if_id_clr, 0); step();

    // reset during STALL discards pending annul
    load_hazard(4); id_annul_req = 1; step();
    idle(); reset = 1; step();
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_cnt", stall_count, 0);
    step(); reset = 0;
    wait_flush_done("flush_len2");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("no_annul_after_rst", if_id_clr, 0); step();
    end

    // saturate the bubble counter
    for (int i = 0; i < CMAX + 20; i++) begin
      load_hazard(6); step();
      idle(); step();
    end
    @(negedge clk);
    check("stall_sat", stall_count, CMAX);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencing controller for the five-stage SPARC pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates PC/nPC and IF/ID load enables and per-register clears.
- Inserts load-use bubbles and applies delay-slot annulment.
- Drives the ID-stage forwarding mux selects for operands MX1/MX2/MX3.
- Runs a post-reset flush sequence and keeps a saturating bubble counter.

Parameters:
FLUSH_CYCLES, 4, cycles all pipeline registers are held cleared after reset deasserts (>=1)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_rd  in  5  rd of instruction in ID (store data source, MX3)
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2 (0 when i=1)
id_use_rd  in  1  ID instruction reads rd (stores)
id_annul_req  in  1  branch in ID requests annul of its delay slot
ex_rd  in  5  destination in EX
ex_rf_en  in  1  EX instruction writes the register file
ex_load  in  1  EX instruction is a load
mem_rd  in  5  destination in MEM
mem_rf_en  in  1  MEM writes the register file
wb_rd  in  5  destination in WB
wb_rf_en  in  1  WB writes the register file
pc_le  out  1  PC load enable
npc_le  out  1  nPC load enable
if_id_le  out  1  IF/ID load enable
if_id_clr  out  1  IF/ID clear
id_ex_clr  out  1  ID/EX clear (bubble)
ex_mem_clr  out  1  EX/MEM clear
mem_wb_clr  out  1  MEM/WB clear
fwd_sel1  out  2  MX1 select: 00 RF, 01 EX, 10 MEM, 11 WB
fwd_sel2  out  2  MX2 select (same encoding)
fwd_sel3  out  2  MX3 select (same encoding)
stall_count  out  CNT_W  saturating count of load-use bubbles inserted
busy  out  1  1 while in FLUSH state

Behaviour:
- FSM states: FLUSH, RUN, STALL.
- Reset (sampled at posedge clk while reset=1):
  - state=FLUSH, flush counter=FLUSH_CYCLES-1, stall_count=0, annul_pending=0.
  - Outputs: pc_le=npc_le=if_id_le=0, all *_clr=1, fwd_sel*=00, busy=1.
  - Reset asserted mid-operation (RUN or STALL) has the same effect and discards pending annul.
- FLUSH:
  - Outputs held as in reset; counter decrements each cycle.
  - At counter==0, next state is RUN. Total FLUSH_CYCLES cycles after reset drops.
- RUN:
  - Defaults: pc_le=npc_le=if_id_le=1, all *_clr=0, busy=0.
  - Load-use hazard: ex_load & ex_rf_en & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd) | (id_use_rd & id_rd==ex_rd)).
  - On hazard, combinationally in the same cycle: pc_le=npc_le=if_id_le=0 and id_ex_clr=1. Next state is STALL.
- STALL:
  - Exactly one cycle; outputs as RUN defaults. stall_count increments (saturates at all-ones). Next state is RUN.
  - The load is now in MEM, so forwarding resolves to 10.
  - Back-to-back hazards re-evaluate normally in RUN.
- Annul:
  - id_annul_req in RUN without hazard: if_id_clr=1 next cycle, for one cycle, registered.
  - id_annul_req coincident with a hazard: set annul_pending and apply if_id_clr one cycle after the stall releases.
  - Requests are ignored in FLUSH.
- Forwarding (combinational, any state except FLUSH; FLUSH forces 00):
  - Per operand, priority EX > MEM > WB > RF.
  - Match requires the stage's rf_en=1 and rd==operand and operand!=0. r0 is never forwarded.
  - A select for an unused operand is don't-care but must be 00.
  - EX match with ex_load=1 still drives 01; the hazard logic masks the consumer.
- Simultaneous events:
  - reset beats everything.
  - Hazard beats annul (deferred, not dropped).
  - An annul with a pending annul already set is merged (one clear).
- Latency: hazard response 0 cycles; annul 1 cycle; stall_count updates on the STALL-cycle edge.

Decomposition:
- Shared package: state encoding (FLUSH/RUN/STALL) and forwarding select constants (FWD_RF=00, FWD_EX=01, FWD_MEM=10, FWD_WB=11).
- One sub-module, forward_select: pure combinational priority matcher for one operand, instantiated three times.

Test Plan:
- Reset for 2 cycles, release → busy=1, all *_clr=1, pc_le=0 for exactly 4 cycles, then pc_le=1, clears=0, busy=0.
- ex_load=1, ex_rf_en=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → same cycle pc_le=if_id_le=0, id_ex_clr=1. Next cycle stall_count=1, and with mem_rd=5, mem_rf_en=1, fwd_sel1=10.
- ex_rd=mem_rd=wb_rd=7 (all rf_en=1, no load), id_rs2=7 → fwd_sel2=01. Drop ex_rf_en → 10. Drop mem_rf_en → 11. Set id_rs2=0 → 00.
- id_annul_req=1 coincident with a load-use hazard → no if_id_clr during the stall cycle. if_id_clr=1 exactly one cycle after the STALL cycle.
- Reset asserted while in STALL with annul_pending=1 → next cycle state FLUSH, stall_count=0. No annul clear emitted after the flush.
- Force 65536 hazards → stall_count saturates at 16'hFFFF.
